// File: rtl/alu_pkg.sv
// Shared constants, ALU control codes and controller state encoding for the
// ALU issue controller slice.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int RES_W = 9;
    localparam int OP_W  = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
    localparam logic [OP_W-1:0] OP_MUL  = 4'h2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'h3;
    localparam logic [OP_W-1:0] OP_SHL  = 4'h4;
    localparam logic [OP_W-1:0] OP_SHR  = 4'h5;
    localparam logic [OP_W-1:0] OP_ROL  = 4'h6;
    localparam logic [OP_W-1:0] OP_ROR  = 4'h7;
    localparam logic [OP_W-1:0] OP_AND  = 4'h8;
    localparam logic [OP_W-1:0] OP_OR   = 4'h9;
    localparam logic [OP_W-1:0] OP_XOR  = 4'hA;
    localparam logic [OP_W-1:0] OP_NOR  = 4'hB;
    localparam logic [OP_W-1:0] OP_NAND = 4'hC;
    localparam logic [OP_W-1:0] OP_XNOR = 4'hD;
    localparam logic [OP_W-1:0] OP_EQ   = 4'hE;
    localparam logic [OP_W-1:0] OP_GT   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CAPT,
        S_RESP
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response bus between the requesting engines (master) and the
// ALU issue controller (slave). Signal names are from the controller's view.
interface alu_issue_ctrl_if #(
    parameter int NUM_REQ = 4
);
    import alu_pkg::*;

    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       i_req_valid;
    logic [ALU_W*NUM_REQ-1:0] i_req_a;
    logic [ALU_W*NUM_REQ-1:0] i_req_b;
    logic [OP_W*NUM_REQ-1:0]  i_req_op;
    logic [NUM_REQ-1:0]       o_req_ready;
    logic                     o_rsp_valid;
    logic [ID_W-1:0]          o_rsp_id;
    logic [RES_W-1:0]         o_rsp_data;
    logic                     i_rsp_ready;

    modport master (
        output i_req_valid, i_req_a, i_req_b, i_req_op, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
    );

    modport slave (
        input  i_req_valid, i_req_a, i_req_b, i_req_op, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first valid request at or after ptr_i (wrapping) wins.
// The index is always computed; the one-hot grant is gated by grant_en_i.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               grant_en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves a value unassigned (which would infer a latch).
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr_i) + off) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
        if (grant_en_i && found) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencer sharing one registered ALU between NUM_REQ requesters:
// arbitrate, issue operands, capture the result, return it with the requester id.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_issue_ctrl_if.slave    bus,
    output logic [ALU_W-1:0]   o_alu_a,
    output logic [ALU_W-1:0]   o_alu_b,
    output logic [OP_W-1:0]    o_alu_cont,
    input  logic [RES_W-1:0]   i_alu_out,
    output logic               o_busy
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ALU_W-1:0]   a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [RES_W-1:0]   rsp_q, rsp_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i      (bus.i_req_valid),
        .ptr_i      (ptr_q),
        .grant_en_i (state_q == S_IDLE),
        .grant_o    (grant),
        .idx_o      (grant_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        rsp_d   = rsp_q;
        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (grant[k]) begin
                            a_d  = bus.i_req_a[ALU_W*k +: ALU_W];
                            b_d  = bus.i_req_b[ALU_W*k +: ALU_W];
                            op_d = bus.i_req_op[OP_W*k +: OP_W];
                        end
                    end
                    id_d    = grant_idx;
                    ptr_d   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = S_CAPT;
            // The ALU registered the EXEC operands on the last edge.
            S_CAPT: begin
                rsp_d   = i_alu_out;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rsp_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values of the others.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rsp_q   <= rsp_d;
        end
    end

    assign bus.o_req_ready = grant;
    assign bus.o_rsp_valid = (state_q == S_RESP);
    assign bus.o_rsp_id    = id_q;
    assign bus.o_rsp_data  = rsp_q;
    assign o_alu_a         = a_q;
    assign o_alu_b         = b_q;
    assign o_alu_cont      = op_q;
    assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a registered, unreset ALU model
// closing the loop from o_alu_* back to i_alu_out.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ALU_W-1:0] alu_a, alu_b;
    logic [OP_W-1:0]  alu_cont;
    logic [RES_W-1:0] alu_out;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int grant_cnt [4];

    alu_issue_ctrl_if #(.NUM_REQ(4)) bus ();

    alu_issue_ctrl #(.NUM_REQ(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_alu_a    (alu_a),
        .o_alu_b    (alu_b),
        .o_alu_cont (alu_cont),
        .i_alu_out  (alu_out),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
        logic [15:0] p;
        p = a * b;
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_MUL:  return p[8:0];
            OP_DIV:  return (b == 8'd0) ? 9'h0FF : {1'b0, a / b};
            OP_SHL:  return {a, 1'b0};
            OP_SHR:  return {1'b0, a >> 1};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOR:  return {1'b0, ~(a | b)};
            OP_GT:   return {8'd0, a > b};
            OP_EQ:   return {8'd0, a == b};
            default: return {1'b0, a};
        endcase
    endfunction

    always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_cont);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op);
        bus.i_req_a[8*k +: 8]  = a;
        bus.i_req_b[8*k +: 8]  = b;
        bus.i_req_op[4*k +: 4] = op;
        bus.i_req_valid[k]     = 1'b1;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        bus.i_req_valid = '0;
        bus.i_req_a     = '0;
        bus.i_req_b     = '0;
        bus.i_req_op    = '0;
        bus.i_rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) grant_cnt[k] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge with requests already driven and the controller idle.
    task automatic serve(input int exp_id, input logic [8:0] exp_data, input bit keep_valid);
        int cycles;
        #1;
        check("grant", 32'(bus.o_req_ready), 32'(1 << exp_id));
        for (int k = 0; k < 4; k++) if (bus.o_req_ready[k]) grant_cnt[k]++;
        @(negedge clk);
        if (!keep_valid) bus.i_req_valid[exp_id] = 1'b0;
        #1;
        check("exec_ready_low", 32'(bus.o_req_ready), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        cycles = 1;
        while (!bus.o_rsp_valid && cycles < 8) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check("latency", cycles, 32'd3);
        check("rsp_id", 32'(bus.o_rsp_id), 32'(exp_id));
        check("rsp_data", 32'(bus.o_rsp_data), 32'(exp_data));
        bus.i_rsp_ready = 1'b1;
        #1;
        check("no_grant_in_resp", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        #1;
        check("rsp_valid_drop", 32'(bus.o_rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
        check("rst_alu", {alu_a, alu_b, alu_cont}, 32'd0);

        // Single request: ADD 200+100 = 300.
        @(negedge clk);
        set_req(1, 8'd200, 8'd100, OP_ADD);
        serve(1, 9'h12C, 1'b0);

        // Simultaneous req0/req2 from ptr 0, then again from ptr 3.
        do_reset();
        set_req(0, 8'd1, 8'd2, OP_ADD);
        set_req(2, 8'd9, 8'd4, OP_SUB);
        serve(0, 9'h003, 1'b0);
        serve(2, 9'h005, 1'b0);
        set_req(0, 8'hF0, 8'h3C, OP_AND);
        set_req(2, 8'hFF, 8'h0F, OP_XOR);
        serve(0, 9'h030, 1'b0);
        serve(2, 9'h0F0, 1'b0);

        // Fairness: all four continuously valid for eight operations.
        do_reset();
        set_req(0, 8'h0F, 8'h30, OP_OR);
        set_req(1, 8'd5, 8'd6, OP_SUB);
        set_req(2, 8'h81, 8'h00, OP_SHL);
        set_req(3, 8'd7, 8'd3, OP_GT);
        serve(0, 9'h03F, 1'b1);
        serve(1, 9'h1FF, 1'b1);
        serve(2, 9'h102, 1'b1);
        serve(3, 9'h001, 1'b1);
        check("fair_half", {grant_cnt[0][7:0], grant_cnt[1][7:0], grant_cnt[2][7:0],
                            grant_cnt[3][7:0]}, 32'h01010101);
        serve(0, 9'h03F, 1'b1);
        serve(1, 9'h1FF, 1'b1);
        serve(2, 9'h102, 1'b1);
        serve(3, 9'h001, 1'b1);
        bus.i_req_valid = '0;
        check("fair_full", {grant_cnt[0][7:0], grant_cnt[1][7:0], grant_cnt[2][7:0],
                            grant_cnt[3][7:0]}, 32'h02020202);

        // Backpressure with DIV 100/7 = 14; req1 waits meanwhile.
        @(negedge clk);
        set_req(3, 8'd100, 8'd7, OP_DIV);
        #1;
        check("div_grant", 32'(bus.o_req_ready), 32'b1000);
        @(negedge clk);
        bus.i_req_valid[3] = 1'b0;
        set_req(1, 8'hFF, 8'h01, OP_ADD);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", 32'(bus.o_rsp_valid), 32'd1);
            check("bp_data", 32'(bus.o_rsp_data), 32'h00E);
            check("bp_id", 32'(bus.o_rsp_id), 32'd3);
            check("bp_ready_low", 32'(bus.o_req_ready), 32'd0);
            @(negedge clk);
        end
        bus.i_rsp_ready = 1'b1;
        #1;
        check("bp_same_cycle", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        #1;
        check("bp_idle", 32'(busy), 32'd0);
        check("bp_next_grant", 32'(bus.o_req_ready), 32'b0010);
        serve(1, 9'h100, 1'b0);

        // Reset pulsed during EXEC, then MUL 16*16.
        @(negedge clk);
        set_req(2, 8'd3, 8'd3, OP_MUL);
        #1;
        check("mr_grant", 32'(bus.o_req_ready), 32'b0100);
        @(negedge clk);
        bus.i_req_valid[2] = 1'b0;
        #1;
        check("mr_exec_ops", {alu_a, alu_b, 4'h0, alu_cont}, {8'd3, 8'd3, 8'h02});
        #1 rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_rsp", {bus.o_rsp_valid, 2'b00, bus.o_rsp_id, 3'b000, bus.o_rsp_data}, 32'd0);
        check("mr_alu", {alu_a, alu_b, alu_cont}, 32'd0);
        check("mr_ready", 32'(bus.o_req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("mr_no_rsp", {busy, bus.o_rsp_valid}, 32'd0);
        @(negedge clk);
        set_req(0, 8'd16, 8'd16, OP_MUL);
        serve(0, 9'h100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
